conv3x3_window: RTL and testbench



---
 rtl/conv_pkg.sv | 25 ++
 rtl/conv_channel_mac.sv | 73 +++++++
 rtl/conv3x3_window.sv | 126 ++++++++++++
 tb/tb_conv3x3_window.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, kernel type and reset kernel for the 3x3
// convolution window stage.
//   R_W/G_W/B_W  - RGB565 channel widths
//   COEFF_WIDTH  - signed coefficient width
//   SUM_WIDTH    - signed accumulator width (holds 9 worst-case products)
//   kernel_t     - 9 coefficients (index 3*row+col) plus right-shift amount
package conv_pkg;
    localparam int R_W         = 5;
    localparam int G_W         = 6;
    localparam int B_W         = 5;
    localparam int COEFF_WIDTH = 8;
    localparam int SUM_WIDTH   = 20;
    localparam int SHIFT_WIDTH = 4;
    localparam int TAPS        = 9;

    typedef struct packed {
        logic [TAPS-1:0][COEFF_WIDTH-1:0] coeff;
        logic [SHIFT_WIDTH-1:0]           shift;
    } kernel_t;

    // Center tap = 1, every other tap 0, no shift.
    localparam kernel_t KERNEL_IDENTITY = kernel_t'({
        {4{COEFF_WIDTH'(0)}}, COEFF_WIDTH'(1), {4{COEFF_WIDTH'(0)}},
        SHIFT_WIDTH'(0)});
endpackage

// File: rtl/conv_channel_mac.sv
// conv_channel_mac: one colour channel of the 3x3 filter.
//   clk_in, rst_n_in - clock, async active-low reset
//   win              - 3x3 channel window, index 3*row+col (unsigned pixels)
//   kernel           - signed coefficients and right-shift
//   bypass           - pass the center pixel through unfiltered
//   pix_out          - registered result
// Stages: products -> sum -> shift/clamp output register.
module conv_channel_mac
    import conv_pkg::*;
#(
    parameter int W = 5
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [TAPS-1:0][W-1:0] win,
    input  kernel_t              kernel,
    input  logic                 bypass,
    output logic [W-1:0]         pix_out
);
    // Zero-extended pixel (W+1) times signed coefficient.
    localparam int PROD_W = W + 1 + COEFF_WIDTH;
    localparam logic signed [SUM_WIDTH-1:0] PIX_MAX = SUM_WIDTH'((1 << W) - 1);

    logic signed [PROD_W-1:0]    prod_q [TAPS];
    logic [SHIFT_WIDTH-1:0]      shift1_q, shift2_q;
    logic                        byp1_q, byp2_q;
    logic [W-1:0]                ctr1_q, ctr2_q;
    logic signed [SUM_WIDTH-1:0] sum_c, sum_q, shr_c;
    logic [W-1:0]                clamp_c;

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < TAPS; i++)
            sum_c = sum_c + SUM_WIDTH'(prod_q[i]);
    end

    always_comb begin
        shr_c   = sum_q >>> shift2_q;
        clamp_c = '0;
        if (shr_c[SUM_WIDTH-1])
            clamp_c = '0;
        else if (shr_c > PIX_MAX)
            clamp_c = '1;
        else
            clamp_c = shr_c[W-1:0];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < TAPS; i++) prod_q[i] <= '0;
            shift1_q <= '0;
            shift2_q <= '0;
            byp1_q   <= 1'b0;
            byp2_q   <= 1'b0;
            ctr1_q   <= '0;
            ctr2_q   <= '0;
            sum_q    <= '0;
            pix_out  <= '0;
        end else begin
            for (int i = 0; i < TAPS; i++)
                prod_q[i] <= PROD_W'($signed({1'b0, win[i]})) *
                             PROD_W'($signed(kernel.coeff[i]));
            shift1_q <= kernel.shift;
            byp1_q   <= bypass;
            ctr1_q   <= win[4];
            sum_q    <= sum_c;
            shift2_q <= shift1_q;
            byp2_q   <= byp1_q;
            ctr2_q   <= ctr1_q;
            pix_out  <= byp2_q ? ctr2_q : clamp_c;
        end
    end
endmodule

// File: rtl/conv3x3_window.sv
// conv3x3_window: builds a sliding 3x3 window from incoming pixel columns
// and filters it per RGB565 channel with a programmable signed kernel.
//   clk_in, rst_n_in   - clock, async active-low reset
//   data_in            - column [0]=top, [1]=center, [2]=bottom row
//   hcount_in/vcount_in- column index / center row index of data_in
//   data_valid_in      - column valid
//   coeffs_in/shift_in - kernel, latched only at the (0,0) column
//   pixel_out, hcount_out, vcount_out, data_valid_out
//                      - filtered pixel 3 edges after the accepting edge
module conv3x3_window #(
    parameter int HRES        = 1280,
    parameter int VRES        = 720,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 8
) (
    input  logic                             clk_in,
    input  logic                             rst_n_in,
    input  logic [2:0][DATA_WIDTH-1:0]       data_in,
    input  logic [$clog2(HRES)-1:0]          hcount_in,
    input  logic [$clog2(VRES)-1:0]          vcount_in,
    input  logic                             data_valid_in,
    input  logic [8:0][COEFF_WIDTH-1:0]      coeffs_in,
    input  logic [3:0]                       shift_in,
    output logic [DATA_WIDTH-1:0]            pixel_out,
    output logic [$clog2(HRES)-1:0]          hcount_out,
    output logic [$clog2(VRES)-1:0]          vcount_out,
    output logic                             data_valid_out
);
    import conv_pkg::*;

    localparam int HW     = $clog2(HRES);
    localparam int VW     = $clog2(VRES);
    localparam int STAGES = 3;

    // Window columns: col_q[0]=W0 (oldest), col_q[2]=W2 (newest).
    logic [2:0][2:0][DATA_WIDTH-1:0] col_q;
    logic                            have_prev_q;
    logic [VW-1:0]                   prev_vc_q;
    kernel_t                         kernel_q;
    logic                            brd_q;
    logic [STAGES:0]                 vld_pipe;
    logic [HW-1:0]                   hc_pipe [STAGES+1];
    logic [VW-1:0]                   vc_pipe [STAGES+1];

    logic          emit_c, brd_c;
    logic [HW-1:0] hc_c;
    logic [VW-1:0] vc_c;

    // A column at h emits column h-1 of the same row; the h==0 column
    // instead flushes the last column of the previous row. Either way the
    // emitted pixel is the post-shift W1 center.
    always_comb begin
        emit_c = data_valid_in & have_prev_q;
        hc_c   = (hcount_in != '0) ? hcount_in - HW'(1) : HW'(HRES - 1);
        vc_c   = (hcount_in != '0) ? vcount_in : prev_vc_q;
        brd_c  = (hc_c == '0) || (hc_c == HW'(HRES - 1)) ||
                 (vc_c == '0) || (vc_c == VW'(VRES - 1));
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            col_q       <= '0;
            have_prev_q <= 1'b0;
            prev_vc_q   <= '0;
            kernel_q    <= KERNEL_IDENTITY;
            brd_q       <= 1'b0;
            vld_pipe    <= '0;
            for (int s = 0; s <= STAGES; s++) begin
                hc_pipe[s] <= '0;
                vc_pipe[s] <= '0;
            end
        end else begin
            if (data_valid_in) begin
                col_q[0]    <= col_q[1];
                col_q[1]    <= col_q[2];
                col_q[2]    <= data_in;
                have_prev_q <= 1'b1;
                prev_vc_q   <= vcount_in;
                // Kernel only changes on frame boundaries.
                if (hcount_in == '0 && vcount_in == '0) begin
                    kernel_q.coeff <= coeffs_in;
                    kernel_q.shift <= shift_in;
                end
            end
            if (emit_c) begin
                hc_pipe[0] <= hc_c;
                vc_pipe[0] <= vc_c;
                brd_q      <= brd_c;
            end
            vld_pipe <= {vld_pipe[STAGES-1:0], emit_c};
            for (int s = 1; s <= STAGES; s++) begin
                hc_pipe[s] <= hc_pipe[s-1];
                vc_pipe[s] <= vc_pipe[s-1];
            end
        end
    end

    // Per-channel windows, tap t = 3*row+col.
    logic [TAPS-1:0][R_W-1:0] r_win;
    logic [TAPS-1:0][G_W-1:0] g_win;
    logic [TAPS-1:0][B_W-1:0] b_win;
    logic [R_W-1:0]           r_out;
    logic [G_W-1:0]           g_out;
    logic [B_W-1:0]           b_out;

    for (genvar t = 0; t < TAPS; t++) begin : g_tap
        assign r_win[t] = col_q[t % 3][t / 3][DATA_WIDTH-1 -: R_W];
        assign g_win[t] = col_q[t % 3][t / 3][G_W+B_W-1 -: G_W];
        assign b_win[t] = col_q[t % 3][t / 3][B_W-1:0];
    end

    conv_channel_mac #(.W(R_W)) u_mac_r (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .win(r_win),
        .kernel(kernel_q), .bypass(brd_q), .pix_out(r_out));
    conv_channel_mac #(.W(G_W)) u_mac_g (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .win(g_win),
        .kernel(kernel_q), .bypass(brd_q), .pix_out(g_out));
    conv_channel_mac #(.W(B_W)) u_mac_b (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .win(b_win),
        .kernel(kernel_q), .bypass(brd_q), .pix_out(b_out));

    assign pixel_out      = {r_out, g_out, b_out};
    assign hcount_out     = hc_pipe[STAGES];
    assign vcount_out     = vc_pipe[STAGES];
    assign data_valid_out = vld_pipe[STAGES];
endmodule

// File: tb/tb_conv3x3_window.sv
// Bench for conv3x3_window on a small 16x6 frame: random columns, kernels
// and gaps against a behavioural model, plus literal spot values.
module tb_conv3x3_window;
    localparam int HRES = 16;
    localparam int VRES = 6;
    localparam int HW   = $clog2(HRES);
    localparam int VW   = $clog2(VRES);

    logic                 clk_in, rst_n_in;
    logic [2:0][15:0]     data_in;
    logic [HW-1:0]        hcount_in;
    logic [VW-1:0]        vcount_in;
    logic                 data_valid_in;
    logic [8:0][7:0]      coeffs_in;
    logic [3:0]           shift_in;
    logic [15:0]          pixel_out;
    logic [HW-1:0]        hcount_out;
    logic [VW-1:0]        vcount_out;
    logic                 data_valid_out;

    conv3x3_window #(.HRES(HRES), .VRES(VRES), .DATA_WIDTH(16), .COEFF_WIDTH(8)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .data_in(data_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .data_valid_in(data_valid_in), .coeffs_in(coeffs_in),
        .shift_in(shift_in), .pixel_out(pixel_out),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .data_valid_out(data_valid_out));

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int tests = 0;
    int fails = 0;
    int out_cnt = 0;
    int cyc = 0;
    logic [15:0] sent_c [HRES][VRES];
    logic [15:0] got    [HRES][VRES];
    int chg_h = -1, chg_v = -1, chg_sh = 0;
    int chg_k [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference filter: plain integer arithmetic per channel.
    function automatic logic [15:0] conv_ref(input logic [2:0][15:0] l,
                                             input logic [2:0][15:0] c,
                                             input logic [2:0][15:0] r,
                                             input int k[9], input int sh);
        int lo [3];
        int wd [3];
        int s, v, mx;
        logic [15:0] p, res;
        lo = '{11, 5, 0};
        wd = '{5, 6, 5};
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            s = 0;
            mx = (1 << wd[ch]) - 1;
            for (int row = 0; row < 3; row++)
                for (int col = 0; col < 3; col++) begin
                    p = (col == 0) ? l[row] : (col == 1) ? c[row] : r[row];
                    v = (int'(p) >> lo[ch]) & mx;
                    s += v * k[3*row+col];
                end
            s = s >>> sh;
            if (s < 0) s = 0;
            if (s > mx) s = mx;
            res = res | 16'(s << lo[ch]);
        end
        return res;
    endfunction

    // ---------------- model + per-cycle compare ----------------
    typedef struct { logic [15:0] pix; int h; int v; int due; } exp_t;
    exp_t q [$];
    logic [2:0][15:0] hist [$];
    int kc [9];
    int ksh = 0;
    bit have_prev = 0;
    int prev_v = 0;

    initial begin
        exp_t e;
        logic [2:0][15:0] zc;
        int eh, ev;
        bit brd, vexp;
        zc = '0;
        hist.push_back(zc);
        hist.push_back(zc);
        for (int i = 0; i < 9; i++) kc[i] = (i == 4) ? 1 : 0;
        forever begin
            @(posedge clk_in);
            if (!rst_n_in) begin
                q.delete();
                hist.delete();
                hist.push_back(zc);
                hist.push_back(zc);
                have_prev = 0;
                prev_v = 0;
                for (int i = 0; i < 9; i++) kc[i] = (i == 4) ? 1 : 0;
                ksh = 0;
            end else if (data_valid_in) begin
                hist.push_back(data_in);
                if (hcount_in == 0 && vcount_in == 0) begin
                    for (int i = 0; i < 9; i++) kc[i] = int'($signed(coeffs_in[i]));
                    ksh = int'(shift_in);
                end
                if (have_prev) begin
                    eh = (hcount_in != 0) ? int'(hcount_in) - 1 : HRES - 1;
                    ev = (hcount_in != 0) ? int'(vcount_in) : prev_v;
                    brd = (eh == 0) || (eh == HRES-1) || (ev == 0) || (ev == VRES-1);
                    e.pix = brd ? hist[1][1] : conv_ref(hist[0], hist[1], hist[2], kc, ksh);
                    e.h = eh;
                    e.v = ev;
                    e.due = cyc + 3;
                    q.push_back(e);
                end
                have_prev = 1;
                prev_v = int'(vcount_in);
                void'(hist.pop_front());
            end
            #1;
            vexp = (q.size() > 0) && (q[0].due == cyc);
            chk("out_valid", data_valid_out, vexp);
            if (data_valid_out) out_cnt++;
            if (vexp) begin
                e = q.pop_front();
                got[e.h][e.v] = pixel_out;
                chk("pixel", pixel_out, e.pix);
                chk("hcount", hcount_out, e.h);
                chk("vcount", vcount_out, e.v);
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_kernel(input int k[9], input int sh);
        for (int i = 0; i < 9; i++) coeffs_in[i] = 8'(k[i]);
        shift_in = 4'(sh);
    endtask

    task automatic send_col(input logic [2:0][15:0] d, input int h, input int v);
        data_in = d;
        hcount_in = HW'(h);
        vcount_in = VW'(v);
        data_valid_in = 1'b1;
        sent_c[h][v] = d[1];
        @(negedge clk_in);
        data_valid_in = 1'b0;
    endtask

    // mode 0: ramp (pixel = h), 1: constant cval, 2: random.
    task automatic send_frame(input int mode, input int h0, input int v0, input int gap_pct,
                              input logic [15:0] cval, input int rst_h, input int rst_v);
        logic [2:0][15:0] d;
        bit post_rst;
        int cnt0;
        post_rst = 0;
        cnt0 = 0;
        for (int v = v0; v < VRES; v++)
            for (int h = (v == v0) ? h0 : 0; h < HRES; h++) begin
                if (h == chg_h && v == chg_v) set_kernel(chg_k, chg_sh);
                for (int r = 0; r < 3; r++)
                    d[r] = (mode == 0) ? 16'(h) : (mode == 1) ? cval : 16'($urandom);
                send_col(d, h, v);
                if (post_rst) begin
                    repeat (4) @(negedge clk_in);
                    chk("no_out_after_rst_col", out_cnt, cnt0);
                    post_rst = 0;
                end
                if (h == rst_h && v == rst_v) begin
                    rst_n_in = 1'b0;
                    #1;
                    chk("async_rst_valid", data_valid_out, 0);
                    chk("async_rst_pixel", pixel_out, 0);
                    @(negedge clk_in);
                    rst_n_in = 1'b1;
                    cnt0 = out_cnt;
                    post_rst = 1;
                end
                if ($urandom_range(99) < gap_pct)
                    repeat ($urandom_range(1, 3)) @(negedge clk_in);
            end
    endtask

    initial begin
        int kbox [9], kneg [9], k127 [9], kr [9];
        logic [2:0][15:0] f8410, fffff, fone;
        for (int i = 0; i < 9; i++) begin
            kbox[i] = 1;
            kneg[i] = (i == 4) ? -8 : 0;
            k127[i] = 127;
        end
        // Pin the reference model with hand-computed values.
        f8410 = {3{16'h8410}};
        fffff = {3{16'hFFFF}};
        fone  = {3{16'h0841}};
        chk("model_box", conv_ref(f8410, f8410, f8410, kbox, 3), 16'h9492);
        chk("model_neg", conv_ref(fone, fone, fone, kneg, 0), 16'h0000);
        chk("model_clamp", conv_ref(fffff, fffff, fffff, k127, 0), 16'hFFFF);

        rst_n_in = 1'b0;
        data_valid_in = 1'b0;
        data_in = '0;
        hcount_in = '0;
        vcount_in = '0;
        for (int i = 0; i < 9; i++) kr[i] = $urandom_range(0, 255) - 128;
        set_kernel(kr, 7);
        repeat (3) @(negedge clk_in);
        chk("rst_valid", data_valid_out, 0);
        chk("rst_pixel", pixel_out, 0);
        chk("rst_hcount", hcount_out, 0);
        chk("rst_vcount", vcount_out, 0);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // First column after reset emits nothing; identity kernel is active.
        send_col({3{16'h0000}}, 0, 1);
        repeat (4) @(negedge clk_in);
        chk("first_col_no_out", out_cnt, 0);
        send_frame(0, 1, 1, 20, 16'h0, -1, -1);
        chk("ident_5_2", got[5][2], 16'd5);
        chk("ident_1_3", got[1][3], 16'd1);
        chk("row_wrap_15_2", got[HRES-1][2], 16'(HRES-1));

        // Box kernel; a mid-frame change must wait for the next frame.
        set_kernel(kbox, 3);
        chg_k = kneg;
        chg_sh = 0;
        chg_h = 8;
        chg_v = 3;
        send_frame(1, 0, 0, 0, 16'h8410, -1, -1);
        chg_h = -1;
        chk("box_4_2", got[4][2], 16'h9492);
        chk("box_after_chg_10_3", got[10][3], 16'h9492);
        chk("box_border_3_0", got[3][0], 16'h8410);

        send_frame(2, 0, 0, 30, 16'h0, -1, -1);
        chk("neg_5_2", got[5][2], 16'h0000);
        chk("neg_6_3", got[6][3], 16'h0000);
        chk("neg_wrap_15_1", got[HRES-1][1], sent_c[HRES-1][1]);

        set_kernel(k127, 0);
        send_frame(1, 0, 0, 10, 16'hFFFF, -1, -1);
        chk("clamp_3_3", got[3][3], 16'hFFFF);
        chk("clamp_7_2", got[7][2], 16'hFFFF);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 9; i++) kr[i] = $urandom_range(0, 255) - 128;
            set_kernel(kr, $urandom_range(0, 15));
            send_frame(2, 0, 0, $urandom_range(0, 50), 16'h0, -1, -1);
        end

        // Reset mid-row with pixels in flight.
        for (int i = 0; i < 9; i++) kr[i] = $urandom_range(0, 255) - 128;
        set_kernel(kr, $urandom_range(0, 6));
        send_frame(2, 0, 0, 0, 16'h0, 7, 2);

        repeat (8) @(negedge clk_in);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end
endmodule
